sw_outport_reader: RTL
======================

Name: sw_outport_reader

Overview:
- Output-port drain stage of the switch, sitting at the read side of N per-input packet FIFOs.
- Round-robin arbitrates among non-empty FIFOs and pops flits with a one-cycle `re` pulse.
- Holds the grant until the packet's last flit has been popped (wormhole lock).
- Presents each flit on a registered valid/ready link toward the output PHY.

Parameters:
- N, 4, number of input FIFOs served; 2..8.
- W, 32, flit width in bits; bit W-1 is the last-flit flag, bits W-2:0 are payload.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fifo_data  in  N*W  flit at the head of each FIFO; slice i = [i*W +: W]. Reads 0 when that FIFO is empty.
- fifo_empty  in  N  per-FIFO empty flag, 1 = empty.
- fifo_re  out  N  per-FIFO pop strobe, one-hot or zero; pops on the same rising edge.
- out_data  out  W  registered flit toward the link.
- out_valid  out  1  out_data holds an unaccepted flit.
- out_ready  in  1  link accepts out_data on a clock edge where out_valid && out_ready.
- busy  out  1  1 while a packet is locked (between its first pop and its last-flit pop).

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - fifo_re=0, out_valid=0, out_data=0, busy=0.
  - Round-robin pointer rr=0, state=IDLE.
  - An in-flight flit is discarded; no pop occurs on the reset edge.
- fifo_re is combinational from state, rr, lock, fifo_empty and out_ready.
  - It is never asserted for an empty FIFO.
  - It is never asserted while the output register is occupied and not being drained.
- Slot free condition: !out_valid || out_ready.
- States:
  - IDLE: no lock.
    - If the slot is free and any fifo_empty[i]=0, grant g = first non-empty index searching rr, rr+1, ... mod N.
    - Assert fifo_re[g] and load out_data<=fifo_data[g], out_valid<=1.
    - If the flit's bit W-1=0: go LOCK with lock=g, busy=1.
    - Else (single-flit packet): stay IDLE, rr<=(g+1) mod N.
  - LOCK: only FIFO `lock` is eligible; other FIFOs are ignored even if non-empty.
    - If the slot is free and fifo_empty[lock]=0: pop lock and load the register.
    - On a popped flit with the last flag: go IDLE, rr<=(lock+1) mod N, busy<=0.
    - If FIFO `lock` is empty mid-packet: wait in LOCK indefinitely, no pop, out_valid drops once the current flit is accepted.
- Register:
  - If out_valid && out_ready and no new pop: out_valid<=0.
  - out_data holds its value while out_valid && !out_ready.
- Latency: FIFO goes non-empty at edge t with the slot free → fifo_re high in cycle t, out_valid high after edge t+1.
- Throughput: 1 flit/cycle when out_ready stays 1 and the FIFO stays non-empty, including back-to-back packets from different inputs with no bubble.
- Simultaneous accept + pop on one edge: the new flit replaces the old one and out_valid stays 1.
- rr wraps N-1→0; rr advances only on a last-flit pop.
- Payload is passed unmodified, including bit W-1.

Optional Feature:
- SW_OUTPORT_STATS_EN defined:
  - Adds port cnt_sel (in, clog2(N) bits) and port cnt_out (out, 16 bits).
  - Per-input 16-bit counters of completed packets: incremented on each last-flit pop, wrapping 0xFFFF→0, cleared by reset.
  - cnt_out = counter[cnt_sel], combinational.
- Macro not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with all FIFOs non-empty → fifo_re=0, out_valid=0, out_data=0, busy=0; release → first pop from FIFO 0 in the cycle after release.
- Round robin: FIFOs 0..3 each hold one single-flit packet 0x8000000i, out_ready=1 → fifo_re pulses 0001,0010,0100,1000 on consecutive cycles; out_data sequence 0x80000000..0x80000003, no gaps.
- Wormhole: FIFO 1 holds 0x00000011, 0x00000012, 0x80000013 and FIFO 2 holds 0x80000020 → three FIFO-1 flits output consecutively, then 0x80000020; busy=1 for exactly the three FIFO-1 pop cycles.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data stable, fifo_re=0 throughout; out_ready=1 → transfer, next pop on that same edge.
- Stall mid-packet: FIFO 0 empties after flit 0x00000005 (not last) while FIFO 3 is non-empty → no pop from FIFO 3; when 0x80000006 arrives in FIFO 0 it is sent next, then FIFO 3.
- Async reset mid-packet: assert rst while busy=1 → outputs clear immediately without a clock; after release, arbitration restarts at rr=0.

Source files
------------

// File: rtl/sw_outport_reader.sv
// Output-port drain stage: round-robin pops packets from N input FIFOs, holding the grant
// for a whole packet, and presents flits on a registered valid/ready link.
// Optional per-input completed-packet counters: define SW_OUTPORT_STATS_EN.
module sw_outport_reader #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       fifo_data,
    input  logic [N-1:0]         fifo_empty,
    output logic [N-1:0]         fifo_re,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SW_OUTPORT_STATS_EN
    input  logic [$clog2(N)-1:0] cnt_sel,
    output logic [15:0]          cnt_out,
`endif
    output logic                 busy
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr, rr_nxt;
    logic [IW-1:0] lock, lock_nxt;
    logic [IW-1:0] grant;
    logic [IW-1:0] sel;
    logic          any_req;
    logic          slot_free;
    logic          pop;
    logic [W-1:0]  flit;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) == N - 1) ? '0 : v + 1'b1;
    endfunction

    // fifo_re is also gated by reset so nothing is popped while rst is held low
    assign slot_free = (!out_valid || out_ready) && rst;

    always_comb begin
        int idx;
        grant   = '0;
        any_req = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= N) idx = idx - N;
            if (!fifo_empty[idx]) begin
                grant   = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        lock_nxt  = lock;
        pop       = 1'b0;
        sel       = (state == LOCK) ? lock : grant;
        flit      = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) flit = fifo_data[i*W +: W];
        end
        case (state)
            IDLE: begin
                if (slot_free && any_req) begin
                    pop = 1'b1;
                    if (flit[W-1]) begin
                        rr_nxt = wrap_inc(grant);
                    end else begin
                        state_nxt = LOCK;
                        lock_nxt  = grant;
                    end
                end
            end
            LOCK: begin
                if (slot_free && !fifo_empty[lock]) begin
                    pop = 1'b1;
                    if (flit[W-1]) begin
                        state_nxt = IDLE;
                        rr_nxt    = wrap_inc(lock);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_re = '0;
        for (int i = 0; i < N; i++) begin
            fifo_re[i] = pop && (sel == IW'(i));
        end
    end

    // Busy covers the first pop of a multi-flit packet as well as the locked cycles
    assign busy = (state == LOCK) || (pop && !flit[W-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr        <= '0;
            lock      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            lock  <= lock_nxt;
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= flit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SW_OUTPORT_STATS_EN
    logic [15:0] cnt [N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (pop && flit[W-1]) begin
            cnt[sel] <= cnt[sel] + 16'd1;
        end
    end

    assign cnt_out = (int'(cnt_sel) < N) ? cnt[cnt_sel] : 16'd0;
`endif

endmodule
